// File: rtl/cs_subtractor_seq.sv
// Sequential WIDTH-bit subtractor: one 4-bit carry-select (borrow form) slice per clock,
// LSB slice first, with borrow-out and two's-complement overflow reported on a done pulse.
module cs_subtractor_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic [WIDTH-1:0] D,
  output logic             bout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NSLICE = WIDTH / 4;
  localparam int unsigned IW     = $clog2(NSLICE + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IW-1:0]    r_idx;
  logic             r_borrow;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic [3:0]       w_a_sl;
  logic [3:0]       w_b_sl;
  logic [4:0]       w_diff0;
  logic [4:0]       w_diff1;
  logic [4:0]       w_sel;
  logic             w_last;

  // Both borrow-in hypotheses are computed for the current slice, then picked by the running borrow.
  always_comb begin
    w_a_sl = '0;
    w_b_sl = '0;
    for (int s = 0; s < int'(NSLICE); s++) begin
      if (r_idx == IW'(s)) begin
        w_a_sl = r_a[4*s +: 4];
        w_b_sl = r_b[4*s +: 4];
      end
    end
    w_diff0 = {1'b0, w_a_sl} - {1'b0, w_b_sl};
    w_diff1 = {1'b0, w_a_sl} - {1'b0, w_b_sl} - 5'd1;
    w_sel   = r_borrow ? w_diff1 : w_diff0;
    w_last  = (r_idx == IW'(NSLICE - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_idx    <= '0;
      r_borrow <= 1'b0;
      r_d      <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a      <= A;
            r_b      <= B;
            r_borrow <= bin;
            r_idx    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          for (int s = 0; s < int'(NSLICE); s++) begin
            if (r_idx == IW'(s)) r_d[4*s +: 4] <= w_sel[3:0];
          end
          r_borrow <= w_sel[4];
          r_idx    <= r_idx + IW'(1);
          // Final slice: its top bit is the result sign used for overflow.
          if (w_last) begin
            r_bout  <= w_sel[4];
            r_ovf   <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sel[3] != r_a[WIDTH-1]);
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign D    = r_d;
  assign bout = r_bout;
  assign ovf  = r_ovf;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_cs_subtractor_seq.sv
// Bench for cs_subtractor_seq: cycle-count reference model checked every cycle,
// plus directed literal cases, held-start, mid-run reset and randomized operations.
module tb_cs_subtractor_seq;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned NSLICE = WIDTH / 4;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] A     = '0;
  logic [WIDTH-1:0] B     = '0;
  logic             bin   = 1'b0;
  logic [WIDTH-1:0] D;
  logic             bout;
  logic             ovf;
  logic             busy;
  logic             done;

  int errors = 0;
  int checks = 0;

  cs_subtractor_seq #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (A),
    .B    (B),
    .bin  (bin),
    .D    (D),
    .bout (bout),
    .ovf  (ovf),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from plain arithmetic: {bout, ovf, D}
  function automatic logic [WIDTH+1:0] ref_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic bi);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             ov;
    full = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(bi);
    d    = full[WIDTH-1:0];
    bo   = ({1'b0, a} < ({1'b0, b} + (WIDTH+1)'(bi)));
    ov   = (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
    return {bo, ov, d};
  endfunction

  // Model: m_cyc counts cycles since the accepting edge (0 = idle).
  int               m_cyc  = 0;
  logic [WIDTH-1:0] m_a    = '0;
  logic [WIDTH-1:0] m_b    = '0;
  logic             m_bin  = 1'b0;
  logic [WIDTH-1:0] e_d    = '0;
  logic             e_bout = 1'b0;
  logic             e_ovf  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc  <= 0;
      e_d    <= '0;
      e_bout <= 1'b0;
      e_ovf  <= 1'b0;
    end else if (m_cyc == 0) begin
      if (start) begin
        m_a   <= A;
        m_b   <= B;
        m_bin <= bin;
        m_cyc <= 1;
      end
    end else if (m_cyc == int'(NSLICE) + 1) begin
      m_cyc <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_cyc == int'(NSLICE)) {e_bout, e_ovf, e_d} <= ref_sub(m_a, m_b, m_bin);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", 32'(busy), 32'(m_cyc != 0));
      check("done", 32'(done), 32'(m_cyc == int'(NSLICE) + 1));
      if (m_cyc == 0 || m_cyc == int'(NSLICE) + 1) begin
        check("D", 32'(D), 32'(e_d));
        check("bout", 32'(bout), 32'(e_bout));
        check("ovf", 32'(ovf), 32'(e_ovf));
      end
    end
  end

  // One operation; scrambles the inputs after capture and returns the result at done.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi,
                        output logic [WIDTH-1:0] d, output logic bo, output logic ov,
                        output int nbusy);
    bit ok;
    ok    = 1'b0;
    nbusy = 0;
    @(negedge clk);
    A = a; B = b; bin = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = WIDTH'($urandom); B = WIDTH'($urandom); bin = 1'($urandom);
    for (int k = 0; k < 20; k++) begin
      if (busy) nbusy++;
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("done_timeout", 32'(ok), 32'd1);
    d  = D;
    bo = bout;
    ov = ovf;
    @(negedge clk);
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             ov;
    int               nb;
    int               ndone;

    #1;
    check("rst_D", 32'(D), 32'h0);
    check("rst_bout", 32'(bout), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    run_op(16'h1234, 16'h0034, 1'b0, d, bo, ov, nb);
    check("t1_D", 32'(d), 32'h1200);
    check("t1_bout", 32'(bo), 32'h0);
    check("t1_ovf", 32'(ov), 32'h0);
    check("t1_busy_cycles", 32'(nb), 32'd5);

    run_op(16'h0000, 16'h0001, 1'b0, d, bo, ov, nb);
    check("t2_D", 32'(d), 32'hFFFF);
    check("t2_bout", 32'(bo), 32'h1);
    check("t2_ovf", 32'(ov), 32'h0);

    run_op(16'h8000, 16'h0001, 1'b0, d, bo, ov, nb);
    check("t3_D", 32'(d), 32'h7FFF);
    check("t3_bout", 32'(bo), 32'h0);
    check("t3_ovf", 32'(ov), 32'h1);

    run_op(16'hFFFF, 16'hFFFF, 1'b1, d, bo, ov, nb);
    check("t4_D", 32'(d), 32'hFFFF);
    check("t4_bout", 32'(bo), 32'h1);
    check("t4_ovf", 32'(ov), 32'h0);

    // start held high with changing operands: accepts at edges 0, 6, 12, 18, 24
    ndone = 0;
    start = 1'b1;
    for (int k = 0; k < 30; k++) begin
      A = WIDTH'($urandom); B = WIDTH'($urandom); bin = 1'($urandom);
      @(negedge clk);
      if (done) ndone++;
    end
    start = 1'b0;
    check("held_done_count", 32'(ndone), 32'd5);
    repeat (8) @(negedge clk);

    // Reset after the second RUN edge
    A = 16'hFFFF; B = 16'h0000; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_D", 32'(D), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_done", 32'(done), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("no_done_after_rst", 32'(ndone), 32'd0);
    run_op(16'h5A5A, 16'h1234, 1'b1, d, bo, ov, nb);
    check("post_rst_D", 32'(d), 32'h4825);
    check("post_rst_bout", 32'(bo), 32'h0);

    // Random operations with gaps and stray start pulses while busy
    for (int i = 0; i < 6000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      A = WIDTH'($urandom); B = WIDTH'($urandom); bin = 1'($urandom);
      if (i % 7 == 0) B = A;
      start = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 20; k++) begin
        if (!busy) break;
        start = 1'($urandom_range(0, 1));
        A = WIDTH'($urandom); B = WIDTH'($urandom); bin = 1'($urandom);
        @(negedge clk);
      end
      start = 1'b0;
    end
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
